// File: rtl/gshare_predictor_if.sv
// Fetch-side predict and ROB-side commit signal bundle for the gshare predictor.
// The master drives fetch and commit information; the slave (the predictor)
// returns the prediction, the history it used, and the commit statistics.
interface gshare_predictor_if #(
  parameter int GHR_W = 8
);
  // fetch side
  logic             IF_valid;
  logic [31:0]      IF_inst;
  logic [31:0]      IF_inst_pc;
  logic             IF_need_jump;
  logic [31:0]      IF_predicted_imm;
  logic [GHR_W-1:0] IF_ghr;
  // commit side
  logic             ROB_input_valid;
  logic             ROB_taken;
  logic [31:0]      ROB_pc;
  logic [GHR_W-1:0] ROB_ghr;
  logic             ROB_mispredict;
  // statistics
  logic [31:0]      stat_updates;
  logic [31:0]      stat_mispredicts;

  modport master (
    output IF_valid, IF_inst, IF_inst_pc,
    output ROB_input_valid, ROB_taken, ROB_pc, ROB_ghr, ROB_mispredict,
    input  IF_need_jump, IF_predicted_imm, IF_ghr,
    input  stat_updates, stat_mispredicts
  );

  modport slave (
    input  IF_valid, IF_inst, IF_inst_pc,
    input  ROB_input_valid, ROB_taken, ROB_pc, ROB_ghr, ROB_mispredict,
    output IF_need_jump, IF_predicted_imm, IF_ghr,
    output stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch predictor.
// A table of saturating counters is indexed by PC (optionally XORed with the
// speculative global history) to predict conditional branches; JAL is always
// taken. Commits train the table and the committed history; a mispredicting
// commit repairs the speculative history from the committed one.
module gshare_predictor #(
  parameter int PHT_IDX_W  = 8,
  parameter int CTR_W      = 2,
  parameter int GHR_W      = 8,
  parameter int USE_GSHARE = 1
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  gshare_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << PHT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [CTR_W-1:0]     pht_reg [ENTRIES];
  logic [GHR_W-1:0]     spec_ghr_reg, spec_ghr_next;
  logic [GHR_W-1:0]     com_ghr_reg, com_ghr_next;
  logic [31:0]          stat_updates_reg, stat_mispredicts_reg;

  logic [6:0]           opcode;
  logic                 is_jal, is_branch;
  logic [31:0]          j_imm, b_imm;
  logic [PHT_IDX_W-1:0] if_idx, rob_idx;
  logic [CTR_W-1:0]     if_ctr, rob_ctr, rob_ctr_next;
  logic                 commit;
  logic                 unused_pc_bits;

  // Table index: word-aligned PC bits, optionally hashed with history.
  function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [31:0] pc,
                                                     input logic [GHR_W-1:0] hist);
    logic [PHT_IDX_W-1:0] base;
    base = pc[PHT_IDX_W+1:2];
    if (USE_GSHARE != 0) return base ^ PHT_IDX_W'(hist);
    return base;
  endfunction

  // Shift one outcome into a history register (also correct for GHR_W = 1).
  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] hist,
                                                input logic bit_in);
    logic [GHR_W:0] wide;
    wide = {hist, bit_in};
    return wide[GHR_W-1:0];
  endfunction

  assign opcode    = bus.IF_inst[6:0];
  assign is_jal    = (opcode == OP_JAL);
  assign is_branch = (opcode == OP_BRANCH);
  assign j_imm = {{12{bus.IF_inst[31]}}, bus.IF_inst[19:12], bus.IF_inst[20],
                  bus.IF_inst[30:21], 1'b0};
  assign b_imm = {{20{bus.IF_inst[31]}}, bus.IF_inst[7], bus.IF_inst[30:25],
                  bus.IF_inst[11:8], 1'b0};

  assign if_idx  = pht_index(bus.IF_inst_pc, spec_ghr_reg);
  assign rob_idx = pht_index(bus.ROB_pc, bus.ROB_ghr);
  assign if_ctr  = pht_reg[if_idx];
  assign rob_ctr = pht_reg[rob_idx];
  assign commit  = rdy & bus.ROB_input_valid;

  assign bus.IF_ghr           = spec_ghr_reg;
  assign bus.stat_updates     = stat_updates_reg;
  assign bus.stat_mispredicts = stat_mispredicts_reg;

  // Address bits outside the index field do not participate in prediction.
  assign unused_pc_bits = ^{bus.IF_inst_pc[31:PHT_IDX_W+2], bus.IF_inst_pc[1:0],
                            bus.ROB_pc[31:PHT_IDX_W+2], bus.ROB_pc[1:0]};

  // Prediction decode: purely combinational, independent of IF_valid and rdy.
  always_comb begin
    bus.IF_need_jump     = 1'b0;
    bus.IF_predicted_imm = '0;
    if (is_jal) begin
      bus.IF_need_jump     = 1'b1;
      bus.IF_predicted_imm = j_imm;
    end else if (is_branch) begin
      bus.IF_need_jump     = if_ctr[CTR_W-1];
      bus.IF_predicted_imm = b_imm;
    end
  end

  // Saturating step of the counter addressed by the committing branch.
  always_comb begin
    rob_ctr_next = rob_ctr;
    if (bus.ROB_taken) begin
      if (rob_ctr != CTR_MAX) rob_ctr_next = rob_ctr + CTR_W'(1);
    end else begin
      if (rob_ctr != '0) rob_ctr_next = rob_ctr - CTR_W'(1);
    end
  end

  // History next-state: a mispredicting commit overrides the fetch-side shift.
  always_comb begin
    com_ghr_next  = com_ghr_reg;
    spec_ghr_next = spec_ghr_reg;
    if (rdy) begin
      if (bus.ROB_input_valid) com_ghr_next = shift_in(com_ghr_reg, bus.ROB_taken);
      if (bus.ROB_input_valid && bus.ROB_mispredict)
        spec_ghr_next = shift_in(com_ghr_reg, bus.ROB_taken);
      else if (bus.IF_valid && is_branch)
        spec_ghr_next = shift_in(spec_ghr_reg, bus.IF_need_jump);
    end
  end

  // Counter table: all entries weakly not-taken on reset, trained on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) pht_reg[i] <= CTR_INIT;
    end else if (commit) begin
      pht_reg[rob_idx] <= rob_ctr_next;
    end
  end

  // Speculative and committed global history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr_reg <= '0;
      com_ghr_reg  <= '0;
    end else begin
      spec_ghr_reg <= spec_ghr_next;
      com_ghr_reg  <= com_ghr_next;
    end
  end

  // Saturating commit and mispredict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_updates_reg     <= '0;
      stat_mispredicts_reg <= '0;
    end else if (commit) begin
      if (stat_updates_reg != '1) stat_updates_reg <= stat_updates_reg + 32'd1;
      if (bus.ROB_mispredict && (stat_mispredicts_reg != '1))
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor: a gshare instance and a bimodal instance see
// identical stimulus; an integer-level model of both is checked every cycle,
// and directed scenarios add hand-computed expectations.
module tb_gshare_predictor;
  localparam logic [31:0] BEQ_P8 = 32'h0000_0463;  // beq, offset +8
  localparam logic [31:0] BEQ_M4 = 32'hFE00_0EE3;  // beq, offset -4
  localparam logic [31:0] JAL_M8 = 32'hFF9F_F0EF;  // jal, offset -8
  localparam logic [31:0] ADDI   = 32'h0010_0093;  // addi x1,x0,1

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        rob_valid = 1'b0;
  logic        rob_taken = 1'b0;
  logic        rob_mp = 1'b0;
  logic [31:0] rob_pc = '0;
  logic [7:0]  rob_ghr = '0;

  int n_vec = 0;
  int n_bad = 0;

  int sat_up_exp [4] = '{0, 1, 1, 1};
  int sat_dn_exp [4] = '{1, 1, 0, 0};
  logic [31:0] stall_inst [3];
  int stall_nj [3]  = '{1, 0, 0};
  logic [31:0] stall_imm [3];

  gshare_predictor_if #(.GHR_W(8)) bus_g ();
  gshare_predictor_if #(.GHR_W(8)) bus_b ();

  assign bus_g.IF_valid        = if_valid;
  assign bus_g.IF_inst         = if_inst;
  assign bus_g.IF_inst_pc      = if_pc;
  assign bus_g.ROB_input_valid = rob_valid;
  assign bus_g.ROB_taken       = rob_taken;
  assign bus_g.ROB_pc          = rob_pc;
  assign bus_g.ROB_ghr         = rob_ghr;
  assign bus_g.ROB_mispredict  = rob_mp;
  assign bus_b.IF_valid        = if_valid;
  assign bus_b.IF_inst         = if_inst;
  assign bus_b.IF_inst_pc      = if_pc;
  assign bus_b.ROB_input_valid = rob_valid;
  assign bus_b.ROB_taken       = rob_taken;
  assign bus_b.ROB_pc          = rob_pc;
  assign bus_b.ROB_ghr         = rob_ghr;
  assign bus_b.ROB_mispredict  = rob_mp;

  gshare_predictor #(.PHT_IDX_W(8), .CTR_W(2), .GHR_W(8), .USE_GSHARE(1)) dut_g (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus_g)
  );
  gshare_predictor #(.PHT_IDX_W(8), .CTR_W(2), .GHR_W(8), .USE_GSHARE(0)) dut_b (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (k=0 gshare, k=1 bimodal) ----------------
  int     m_pht [2][256];
  int     m_spec [2];
  int     m_com;
  longint m_upd, m_mis;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) m_pht[k][i] = 1;
      m_spec[k] = 0;
    end
    m_com = 0;
    m_upd = 0;
    m_mis = 0;
  endfunction

  function automatic int m_idx(input int k, input logic [31:0] pc, input int hist);
    int word;
    word = int'(pc >> 2);
    if (k == 0) return (word ^ hist) % 256;
    return word % 256;
  endfunction

  function automatic void model_predict(input int k, output logic nj, output logic [31:0] imm);
    logic [19:0] j20;
    logic [11:0] b12;
    int off;
    nj  = 1'b0;
    imm = '0;
    if (if_inst[6:0] == 7'h6F) begin
      j20 = {if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21]};
      off = int'($signed(j20));
      imm = 32'(off * 2);
      nj  = 1'b1;
    end else if (if_inst[6:0] == 7'h63) begin
      b12 = {if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8]};
      off = int'($signed(b12));
      imm = 32'(off * 2);
      nj  = (m_pht[k][m_idx(k, if_pc, m_spec[k])] >= 2);
    end
  endfunction

  function automatic void model_step();
    logic        nj [2];
    logic [31:0] imm;
    int          new_com, i;
    if (!rdy) return;
    for (int k = 0; k < 2; k++) model_predict(k, nj[k], imm);
    new_com = ((m_com * 2) + (rob_taken ? 1 : 0)) % 256;
    if (rob_valid) begin
      for (int k = 0; k < 2; k++) begin
        i = m_idx(k, rob_pc, int'(rob_ghr));
        if (rob_taken) m_pht[k][i] = (m_pht[k][i] < 3) ? m_pht[k][i] + 1 : 3;
        else           m_pht[k][i] = (m_pht[k][i] > 0) ? m_pht[k][i] - 1 : 0;
      end
      if (m_upd < 64'hFFFF_FFFF) m_upd++;
      if (rob_mp && m_mis < 64'hFFFF_FFFF) m_mis++;
    end
    for (int k = 0; k < 2; k++) begin
      if (rob_valid && rob_mp) m_spec[k] = new_com;
      else if (if_valid && if_inst[6:0] == 7'h63)
        m_spec[k] = ((m_spec[k] * 2) + (nj[k] ? 1 : 0)) % 256;
    end
    if (rob_valid) m_com = new_com;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) if (rst) model_step();
  always @(negedge rst) model_reset();

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic        nj;
    logic [31:0] imm;
    model_predict(0, nj, imm);
    check("g_need_jump", 32'(bus_g.IF_need_jump), 32'(nj));
    check("g_imm", bus_g.IF_predicted_imm, imm);
    check("g_ghr", 32'(bus_g.IF_ghr), 32'(m_spec[0]));
    check("g_updates", bus_g.stat_updates, 32'(m_upd));
    check("g_mispredicts", bus_g.stat_mispredicts, 32'(m_mis));
    model_predict(1, nj, imm);
    check("b_need_jump", 32'(bus_b.IF_need_jump), 32'(nj));
    check("b_imm", bus_b.IF_predicted_imm, imm);
    check("b_ghr", 32'(bus_b.IF_ghr), 32'(m_spec[1]));
    check("b_updates", bus_b.stat_updates, 32'(m_upd));
  end

  task automatic set_if(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  task automatic set_rob(input logic v, input logic t, input logic [31:0] pc,
                         input logic [7:0] g, input logic mp);
    rob_valid = v;
    rob_taken = t;
    rob_pc    = pc;
    rob_ghr   = g;
    rob_mp    = mp;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    stall_inst[0] = JAL_M8;       stall_imm[0] = 32'hFFFF_FFF8;
    stall_inst[1] = ADDI;         stall_imm[1] = 32'h0;
    stall_inst[2] = BEQ_M4;       stall_imm[2] = 32'hFFFF_FFFC;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rdy = 1'b1;

    // reset state
    set_if(1'b0, BEQ_P8, 32'h100);
    set_rob(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("rst_pred", 32'(bus_g.IF_need_jump), 32'd0);
    check("rst_imm", bus_g.IF_predicted_imm, 32'd8);
    check("rst_ghr", 32'(bus_g.IF_ghr), 32'd0);
    check("rst_upd", bus_g.stat_updates, 32'd0);
    check("rst_mis", bus_g.stat_mispredicts, 32'd0);
    next_cycle();

    // saturation upward: prediction shows the pre-update counter each cycle
    for (int i = 0; i < 4; i++) begin
      set_rob(1'b1, 1'b1, 32'h100, 8'h00, 1'b0);
      @(negedge clk);
      check("sat_up_pred", 32'(bus_g.IF_need_jump), 32'(sat_up_exp[i]));
      next_cycle();
    end
    set_rob(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("sat_up_final", 32'(bus_g.IF_need_jump), 32'd1);
    check("sat_up_upd", bus_g.stat_updates, 32'd4);
    next_cycle();

    // saturation downward
    for (int i = 0; i < 4; i++) begin
      set_rob(1'b1, 1'b0, 32'h100, 8'h00, 1'b0);
      @(negedge clk);
      check("sat_dn_pred", 32'(bus_g.IF_need_jump), 32'(sat_dn_exp[i]));
      next_cycle();
    end
    set_rob(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("sat_dn_final", 32'(bus_g.IF_need_jump), 32'd0);
    check("sat_dn_upd", bus_g.stat_updates, 32'd8);
    next_cycle();

    // XOR aliasing: pc 0x104 with history 0x01 trains entry 0x40 only in gshare
    repeat (2) begin
      set_rob(1'b1, 1'b1, 32'h104, 8'h01, 1'b0);
      next_cycle();
    end
    set_rob(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("xor_gshare_pred", 32'(bus_g.IF_need_jump), 32'd1);
    check("xor_bimodal_pred", 32'(bus_b.IF_need_jump), 32'd0);
    next_cycle();

    // asynchronous reset mid-cycle with a commit pending
    set_rob(1'b1, 1'b1, 32'h100, 8'h00, 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_pred", 32'(bus_g.IF_need_jump), 32'd0);
    check("midrst_upd", bus_g.stat_updates, 32'd0);
    set_rob(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    #3 rst = 1'b1;
    set_rob(1'b1, 1'b1, 32'h100, 8'h00, 1'b0);
    @(negedge clk);
    check("postrst_pred", 32'(bus_g.IF_need_jump), 32'd0);
    next_cycle();
    set_rob(1'b1, 1'b0, 32'h200, 8'h00, 1'b0);
    @(negedge clk);
    check("postrst_first_edge", 32'(bus_g.IF_need_jump), 32'd1);
    check("postrst_upd", bus_g.stat_updates, 32'd1);
    next_cycle();
    set_rob(1'b1, 1'b1, 32'h200, 8'h00, 1'b0);
    next_cycle();

    // recovery collision: com_ghr is 0x05 here
    set_if(1'b1, BEQ_P8, 32'h100);
    set_rob(1'b1, 1'b1, 32'h300, 8'h00, 1'b1);
    @(negedge clk);
    check("coll_pred", 32'(bus_g.IF_need_jump), 32'd1);
    next_cycle();
    set_if(1'b0, BEQ_P8, 32'h100);
    set_rob(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("coll_ghr_g", 32'(bus_g.IF_ghr), 32'h0B);
    check("coll_ghr_b", 32'(bus_b.IF_ghr), 32'h0B);
    check("coll_mis", bus_g.stat_mispredicts, 32'd1);
    check("coll_upd", bus_g.stat_updates, 32'd4);

    // stall: everything active but rdy low
    rdy = 1'b0;
    set_rob(1'b1, 1'b1, 32'h100, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_if(1'b1, stall_inst[i], 32'h100);
      @(negedge clk);
      check("stall_nj", 32'(bus_g.IF_need_jump), 32'(stall_nj[i]));
      check("stall_imm", bus_g.IF_predicted_imm, stall_imm[i]);
      check("stall_ghr", 32'(bus_g.IF_ghr), 32'h0B);
      check("stall_upd", bus_g.stat_updates, 32'd4);
      check("stall_mis", bus_g.stat_mispredicts, 32'd1);
      next_cycle();
    end
    rdy = 1'b1;

    // JAL with a not-taken commit at 0x100 (entry 10 -> 01 if the stall held it)
    set_if(1'b1, JAL_M8, 32'h100);
    set_rob(1'b1, 1'b0, 32'h100, 8'h00, 1'b0);
    @(negedge clk);
    check("jal_nj", 32'(bus_g.IF_need_jump), 32'd1);
    check("jal_imm", bus_g.IF_predicted_imm, 32'hFFFF_FFF8);
    next_cycle();
    set_if(1'b1, ADDI, 32'h104);
    set_rob(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("addi_nj", 32'(bus_g.IF_need_jump), 32'd0);
    check("addi_imm", bus_g.IF_predicted_imm, 32'd0);
    check("jal_ghr_kept", 32'(bus_g.IF_ghr), 32'h0B);
    next_cycle();
    set_if(1'b0, BEQ_P8, 32'h100);
    @(negedge clk);
    check("addi_ghr_kept", 32'(bus_g.IF_ghr), 32'h0B);
    check("stall_table_kept", 32'(bus_b.IF_need_jump), 32'd0);
    check("final_upd", bus_g.stat_updates, 32'd5);
    next_cycle();

    // fetched branch predicted not-taken shifts a 0 into spec history
    set_if(1'b1, BEQ_P8, 32'h100);
    @(negedge clk);
    check("shift_pred", 32'(bus_g.IF_need_jump), 32'd0);
    next_cycle();
    set_if(1'b0, ADDI, 32'h0);
    @(negedge clk);
    check("shift_ghr", 32'(bus_g.IF_ghr), 32'h16);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
